// File: rtl/burst_sequencer.sv
// Burst sequencer for an NCO/DAC path: sync pulse, N waveform periods, then a timed gap.
// Define AWG_BURST_REPEAT_EN to make the gap exit re-sync and repeat bursts until enable falls.
//
// state | meaning
// IDLE  | waiting for trigger with enable high
// SYNC  | one-cycle NCO phase clear, output muted
// RUN   | NCO running, counting periods on phase_msb falling wraps
// GAP   | NCO stopped, output muted, waiting gap_ms milliseconds
module burst_sequencer #(
   parameter int CLK_HZ = 100000000,
   parameter int CNT_W  = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             trigger,
   input  logic [CNT_W-1:0] burst_cycles,
   input  logic [CNT_W-1:0] gap_ms,
   input  logic             phase_msb,
   output logic             nco_run,
   output logic             nco_sync,
   output logic             out_mute,
   output logic             busy,
   output logic [CNT_W-1:0] cycles_done,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SYNC = 2'b01,
      RUN  = 2'b10,
      GAP  = 2'b11
   } state_t;

   localparam int TICK  = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
   localparam int PRE_W = (TICK > 1) ? $clog2(TICK) : 1;
   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(TICK - 1);

`ifdef AWG_BURST_REPEAT_EN
   localparam state_t GAP_EXIT = SYNC;
`else
   localparam state_t GAP_EXIT = IDLE;
`endif

   state_t           st_q, st_d;
   logic             msb_q;
   logic [CNT_W-1:0] burst_lat, gap_lat, target;
   logic [CNT_W-1:0] cnt_d, gap_cnt_q, gap_cnt_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             latch_en, wrap;

   assign target = (burst_lat == '0) ? CNT_W'(1) : burst_lat;
   assign wrap   = msb_q & ~phase_msb;
   assign state  = st_q;

   always_comb begin
      st_d      = st_q;
      cnt_d     = cycles_done;
      gap_cnt_d = gap_cnt_q;
      pre_d     = pre_q;
      latch_en  = 1'b0;
      if (!enable) begin
         st_d = IDLE;
      end else begin
         case (st_q)
            IDLE: begin
               if (trigger) begin
                  latch_en = 1'b1;
                  st_d     = SYNC;
               end
            end
            SYNC: st_d = RUN;
            RUN: begin
               if (wrap && cycles_done < target) begin
                  cnt_d = cycles_done + CNT_W'(1);
                  if (cnt_d == target) st_d = GAP;
               end
            end
            GAP: begin
               if (gap_lat == '0) begin
                  st_d = GAP_EXIT;
               end else if (pre_q == PRE_TC) begin
                  pre_d = '0;
                  if (gap_cnt_q < gap_lat) gap_cnt_d = gap_cnt_q + CNT_W'(1);
                  if (gap_cnt_d == gap_lat) st_d = GAP_EXIT;
               end else begin
                  pre_d = pre_q + PRE_W'(1);
               end
            end
            default: st_d = IDLE;
         endcase
      end
      if (st_d == SYNC) cnt_d = '0;
      // Timers restart on every GAP entry, including entry straight from RUN.
      if (st_d == GAP && st_q != GAP) begin
         pre_d     = '0;
         gap_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q        <= IDLE;
         msb_q       <= 1'b0;
         burst_lat   <= '0;
         gap_lat     <= '0;
         cycles_done <= '0;
         gap_cnt_q   <= '0;
         pre_q       <= '0;
         nco_run     <= 1'b0;
         nco_sync    <= 1'b0;
         out_mute    <= 1'b1;
         busy        <= 1'b0;
      end else begin
         st_q        <= st_d;
         msb_q       <= (st_q == SYNC) ? 1'b0 : phase_msb;
         cycles_done <= cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         pre_q       <= pre_d;
         if (latch_en) begin
            burst_lat <= burst_cycles;
            gap_lat   <= gap_ms;
         end
         nco_run  <= (st_d == RUN);
         nco_sync <= (st_d == SYNC);
         out_mute <= (st_d != RUN);
         busy     <= (st_d != IDLE);
      end
   end

endmodule

// File: tb/tb_burst_sequencer.sv
// Self-checking bench for burst_sequencer with a 4-bit NCO model (msb toggles every 8 clocks).
// Expected burst results are queued at trigger time and compared when the burst leaves GAP.
module tb_burst_sequencer;
   localparam int CNT_W = 10;
`ifdef AWG_BURST_REPEAT_EN
   localparam logic [1:0] EXP_END = 2'b01;
`else
   localparam logic [1:0] EXP_END = 2'b00;
`endif

   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, trigger = 1'b0;
   logic [CNT_W-1:0] burst_cycles = '0, gap_ms = '0;
   logic phase_msb, nco_run, nco_sync, out_mute, busy;
   logic [CNT_W-1:0] cycles_done;
   logic [1:0] state;
   logic [3:0] acc;

   burst_sequencer #(.CLK_HZ(100000), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger),
      .burst_cycles(burst_cycles), .gap_ms(gap_ms), .phase_msb(phase_msb),
      .nco_run(nco_run), .nco_sync(nco_sync), .out_mute(out_mute), .busy(busy),
      .cycles_done(cycles_done), .state(state));

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc <= 4'd0;
      else if (nco_sync) acc <= 4'd0;
      else if (nco_run) acc <= acc + 4'd1;
   end
   assign phase_msb = acc[3];

   typedef struct {int cyc; int gap; logic [1:0] end_st;} exp_t;
   exp_t sb[$];
   exp_t e;

   int checks = 0, errors = 0;
   int m_sync, m_wraps, m_gap, e_sync, e_wraps, e_gap;
   logic [CNT_W-1:0] m_sync_cd, e_cd;
   logic [1:0] prev_st, e_state;
   logic tb_msb, end_seen;
   bit to;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_st = 2'b00;
         tb_msb  = 1'b0;
      end else begin
         if (prev_st == 2'b11 && state != 2'b11 && !end_seen) begin
            end_seen = 1'b1; e_state = state; e_cd = cycles_done;
            e_sync = m_sync; e_wraps = m_wraps; e_gap = m_gap;
         end
         if (state == 2'b01) begin m_sync++; m_sync_cd = cycles_done; end
         if (state == 2'b10 && tb_msb && !phase_msb) m_wraps++;
         if (state == 2'b11) m_gap++;
         tb_msb  = (state == 2'b01) ? 1'b0 : phase_msb;
         prev_st = state;
      end
   end

   task automatic arm();
      @(negedge clk); #1;
      m_sync = 0; m_wraps = 0; m_gap = 0; m_sync_cd = '1; end_seen = 1'b0;
   endtask

   task automatic pulse(input int b, input int g);
      @(negedge clk);
      burst_cycles = CNT_W'(b); gap_ms = CNT_W'(g); trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic push(input int b, input int g);
      exp_t x;
      x.cyc = (b == 0) ? 1 : b;
      x.gap = (g == 0) ? 1 : g * 100;
      x.end_st = EXP_END;
      sb.push_back(x);
   endtask

   task automatic wait_end(output bit tmo);
      tmo = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk); #1;
         if (end_seen) begin tmo = 1'b0; break; end
      end
   endtask

   task automatic wait_cond_run1(output bit tmo);
      tmo = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (state == 2'b10 && cycles_done == 1) begin tmo = 1'b0; break; end
      end
   endtask

   task automatic stop_repeat();
      @(negedge clk); enable = 1'b0;
      @(negedge clk); @(negedge clk); enable = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state); end
      checks++; if (nco_run !== 1'b0) begin errors++; $display("FAIL reset_run got %b exp 0", nco_run); end
      checks++; if (nco_sync !== 1'b0) begin errors++; $display("FAIL reset_sync got %b exp 0", nco_sync); end
      checks++; if (out_mute !== 1'b1) begin errors++; $display("FAIL reset_mute got %b exp 1", out_mute); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (cycles_done !== '0) begin errors++; $display("FAIL reset_cd got %0d exp 0", cycles_done); end
   endtask

   task automatic test_burst(input string nm, input int b, input int g);
      arm();
      push(b, g);
      pulse(b, g);
      wait_end(to);
      checks++;
      if (to) begin errors++; $display("FAIL %s_timeout got no GAP exit exp exit", nm); end
      else begin
         e = sb.pop_front();
         checks++; if (e_sync !== 1) begin errors++; $display("FAIL %s_sync_pulses got %0d exp 1", nm, e_sync); end
         checks++; if (e_wraps !== e.cyc) begin errors++; $display("FAIL %s_wraps got %0d exp %0d", nm, e_wraps, e.cyc); end
         checks++; if (e_cd !== CNT_W'(e.cyc)) begin errors++; $display("FAIL %s_cycles_done got %0d exp %0d", nm, e_cd, e.cyc); end
         checks++; if (e_gap !== e.gap) begin errors++; $display("FAIL %s_gap_len got %0d exp %0d", nm, e_gap, e.gap); end
         checks++; if (e_state !== e.end_st) begin errors++; $display("FAIL %s_end_state got %b exp %b", nm, e_state, e.end_st); end
         checks++; if (m_sync_cd !== '0) begin errors++; $display("FAIL %s_sync_cd got %0d exp 0", nm, m_sync_cd); end
      end
      stop_repeat();
   endtask

   task automatic test_retrigger();
      arm();
      push(3, 0);
      pulse(3, 0);
      wait_cond_run1(to);
      checks++; if (to) begin errors++; $display("FAIL retrig_reach_run got timeout exp RUN cd=1"); end
      trigger = 1'b1; burst_cycles = 10'd7;
      @(negedge clk); trigger = 1'b0;
      checks++; if (state !== 2'b10 || cycles_done !== 10'd1) begin
         errors++; $display("FAIL retrig_hold got st=%b cd=%0d exp st=10 cd=1", state, cycles_done); end
      wait_end(to);
      checks++;
      if (to) begin errors++; $display("FAIL retrig_timeout got no GAP exit exp exit"); end
      else begin
         e = sb.pop_front();
         checks++; if (e_sync !== 1) begin errors++; $display("FAIL retrig_sync_pulses got %0d exp 1", e_sync); end
         checks++; if (e_cd !== CNT_W'(e.cyc)) begin errors++; $display("FAIL retrig_cycles_done got %0d exp %0d", e_cd, e.cyc); end
      end
      stop_repeat();
   endtask

   task automatic test_enable_drop();
      arm();
      pulse(3, 2);
      wait_cond_run1(to);
      checks++; if (to) begin errors++; $display("FAIL endrop_reach_run got timeout exp RUN cd=1"); end
      enable = 1'b0;
      @(negedge clk);
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL endrop_state got %b exp 00", state); end
      checks++; if (nco_run !== 1'b0 || out_mute !== 1'b1 || nco_sync !== 1'b0) begin
         errors++; $display("FAIL endrop_outs got run=%b mute=%b sync=%b exp 0 1 0", nco_run, out_mute, nco_sync); end
      checks++; if (cycles_done !== 10'd1) begin errors++; $display("FAIL endrop_cd_hold got %0d exp 1", cycles_done); end
      enable = 1'b1;
   endtask

   task automatic test_enable_priority();
      arm();
      enable = 1'b0;
      pulse(2, 0);
      @(negedge clk);
      checks++; if (state !== 2'b00 || busy !== 1'b0 || m_sync !== 0) begin
         errors++; $display("FAIL en_priority got st=%b busy=%b syncs=%0d exp 00 0 0", state, busy, m_sync); end
      enable = 1'b1;
   endtask

   task automatic test_reset_mid_gap();
      arm();
      pulse(1, 2);
      to = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (state == 2'b11) begin to = 1'b0; break; end
      end
      checks++; if (to) begin errors++; $display("FAIL rstgap_reach_gap got timeout exp GAP"); end
      repeat (10) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++; if (state !== 2'b00 || busy !== 1'b0 || nco_run !== 1'b0 || nco_sync !== 1'b0 || out_mute !== 1'b1 || cycles_done !== '0) begin
         errors++; $display("FAIL rstgap_async got st=%b busy=%b run=%b sync=%b mute=%b cd=%0d exp 00 0 0 0 1 0",
                            state, busy, nco_run, nco_sync, out_mute, cycles_done); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      arm();
      repeat (5) @(negedge clk);
      checks++; if (m_sync !== 0 || state !== 2'b00) begin
         errors++; $display("FAIL rstgap_no_sync got syncs=%0d st=%b exp 0 00", m_sync, state); end
   endtask

   initial begin
      test_reset();
      test_burst("basic", 3, 2);
      test_burst("zero_burst", 0, 1);
      test_burst("zero_gap", 2, 0);
      test_retrigger();
      test_enable_drop();
      test_enable_priority();
      test_reset_mid_gap();
      test_burst("after_rst", 2, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got stuck exp finish");
      $fatal(1);
   end
endmodule
